// File: rtl/esc_rx_responder_if.sv
// Escalation link between sender (master) and responder (slave).
// Level-coded link, no valid/ready. Each side drives its 2-bit differential
// pair every cycle, synchronous to clk: esc_tx = {esc_p, esc_n} and
// esc_rx = {resp_p, resp_n}. A valid level has p != n. p == n is a
// signal-integrity fault.
interface esc_rx_responder_if;
    logic [1:0] esc_tx;
    logic [1:0] esc_rx;

    modport master (output esc_tx, input esc_rx);
    modport slave  (input esc_tx, output esc_rx);
endinterface

// File: rtl/esc_rx_responder.sv
// Escalation receiver: decodes esc_tx, answers pings/escalations on esc_rx, drives esc_req_o.
// Optional ESC_RX_SIGINT_ESC_EN: a signal-integrity fault also raises esc_req_o (fail-safe).
module esc_rx_responder #(
    parameter int unsigned EscCntW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    esc_rx_responder_if.slave    esc_if,
    output logic                 esc_req_o,
    output logic                 sigint_o,
    output logic                 ping_ok_o,
    output logic [EscCntW-1:0]   esc_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ESC    = 2'd2,
        SIGINT = 2'd3
    } state_e;

`ifdef ESC_RX_SIGINT_ESC_EN
    localparam logic SigintReq = 1'b1;
`else
    localparam logic SigintReq = 1'b0;
`endif

    state_e               state_q, state_d;
    logic                 resp_p_q, resp_p_d;
    logic                 resp_n_q, resp_n_d;
    logic                 esc_req_q, esc_req_d;
    logic                 sigint_q, sigint_d;
    logic                 ping_ok_q, ping_ok_d;
    logic [EscCntW-1:0]   esc_cnt_q, esc_cnt_d;

    logic lvl_hi, lvl_lo, sig_err;

    assign lvl_hi  =  esc_if.esc_tx[1] & ~esc_if.esc_tx[0];
    assign lvl_lo  = ~esc_if.esc_tx[1] &  esc_if.esc_tx[0];
    assign sig_err =  esc_if.esc_tx[1] == esc_if.esc_tx[0];

    always_comb begin
        state_d   = state_q;
        resp_p_d  = 1'b0;
        resp_n_d  = 1'b1;
        esc_req_d = 1'b0;
        sigint_d  = 1'b0;
        ping_ok_d = 1'b0;
        esc_cnt_d = esc_cnt_q;

        if (sig_err) begin
            // Fault pattern: both rails equal, starting high and toggling while the fault persists.
            state_d   = SIGINT;
            sigint_d  = 1'b1;
            esc_req_d = SigintReq;
            if (state_q == SIGINT) begin
                resp_p_d = ~resp_p_q;
                resp_n_d = ~resp_p_q;
            end else begin
                resp_p_d = 1'b1;
                resp_n_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lvl_hi) begin
                        state_d  = CHECK;
                        resp_p_d = 1'b1;
                        resp_n_d = 1'b0;
                    end
                end
                CHECK: begin
                    if (lvl_hi) begin
                        state_d   = ESC;
                        esc_req_d = 1'b1;
                        esc_cnt_d = EscCntW'(1);
                    end else if (lvl_lo) begin
                        state_d   = IDLE;
                        ping_ok_d = 1'b1;
                    end
                end
                ESC: begin
                    if (lvl_hi) begin
                        esc_req_d = 1'b1;
                        resp_p_d  = ~resp_p_q;
                        resp_n_d  = resp_p_q;
                        if (esc_cnt_q != {EscCntW{1'b1}}) begin
                            esc_cnt_d = esc_cnt_q + EscCntW'(1);
                        end
                    end else if (lvl_lo) begin
                        state_d = IDLE;
                    end
                end
                SIGINT: begin
                    // A clean high level after a fault is taken as a fresh request.
                    if (lvl_hi) begin
                        state_d  = CHECK;
                        resp_p_d = 1'b1;
                        resp_n_d = 1'b0;
                    end else if (lvl_lo) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            resp_p_q  <= 1'b0;
            resp_n_q  <= 1'b1;
            esc_req_q <= 1'b0;
            sigint_q  <= 1'b0;
            ping_ok_q <= 1'b0;
            esc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            resp_p_q  <= resp_p_d;
            resp_n_q  <= resp_n_d;
            esc_req_q <= esc_req_d;
            sigint_q  <= sigint_d;
            ping_ok_q <= ping_ok_d;
            esc_cnt_q <= esc_cnt_d;
        end
    end

    assign esc_if.esc_rx = {resp_p_q, resp_n_q};
    assign esc_req_o     = esc_req_q;
    assign sigint_o      = sigint_q;
    assign ping_ok_o     = ping_ok_q;
    assign esc_cnt_o     = esc_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_esc_rx_responder.sv
// Directed bench for esc_rx_responder: per-cycle expected outputs go into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_esc_rx_responder;

    localparam int unsigned CNT_W = 4;
`ifdef ESC_RX_SIGINT_ESC_EN
    localparam logic SIG_REQ = 1'b1;
`else
    localparam logic SIG_REQ = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             esc_req_o;
    logic             sigint_o;
    logic             ping_ok_o;
    logic [CNT_W-1:0] esc_cnt_o;
    logic [1:0]       state_o;

    esc_rx_responder_if esc_if ();

    esc_rx_responder #(.EscCntW(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .esc_if    (esc_if),
        .esc_req_o (esc_req_o),
        .sigint_o  (sigint_o),
        .ping_ok_o (ping_ok_o),
        .esc_cnt_o (esc_cnt_o),
        .state_o   (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Expected word per cycle: {resp_p, resp_n, esc_req, sigint, ping_ok, esc_cnt[3:0]}
    logic [8:0] exp_q[$];
    string      name_q[$];
    int         n_tests;
    int         n_fail;

    function automatic logic [8:0] mk(input logic p, input logic n, input logic req,
                                      input logic sig, input logic ping,
                                      input logic [3:0] cnt);
        return {p, n, req, sig, ping, cnt};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] exp_w;
            logic [8:0] got_w;
            string      nm;
            exp_w = exp_q.pop_front();
            nm    = name_q.pop_front();
            got_w = {esc_if.esc_rx, esc_req_o, sigint_o, ping_ok_o, esc_cnt_o};
            n_tests++;
            if (got_w !== exp_w) begin
                n_fail++;
                $display("FAIL %s t=%0t got {rx,req,sig,ping,cnt}=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                         nm, $time, got_w[8:7], got_w[6], got_w[5], got_w[4], got_w[3:0],
                         exp_w[8:7], exp_w[6], exp_w[5], exp_w[4], exp_w[3:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive this cycle's input and queue the outputs required in this same cycle.
    task automatic step(input logic [1:0] tx, input logic [8:0] exp_w, input string nm);
        @(posedge clk);
        #1;
        esc_if.esc_tx = tx;
        exp_q.push_back(exp_w);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n, input logic [3:0] cnt, input string nm);
        for (int i = 0; i < n; i++) step(2'b01, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cnt), nm);
    endtask

    // Escalation body: j-th cycle after entering ESC, esc_p still high.
    task automatic esc_run(input int from_j, input int to_j, input string nm);
        for (int j = from_j; j <= to_j; j++) begin
            logic [3:0] c;
            logic       p;
            c = (j + 1 > 15) ? 4'd15 : 4'(j + 1);
            p = (j % 2) == 1;
            step(2'b10, mk(p, ~p, 1'b1, 1'b0, 1'b0, c), nm);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        esc_if.esc_tx = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset
        idle(10, 4'd0, "reset_idle");

        // 2: single ping
        idle(5, 4'd0, "ping_pre");
        step(2'b10, mk(0, 1, 0, 0, 0, 4'd0), "ping_c5");
        step(2'b01, mk(1, 0, 0, 0, 0, 4'd0), "ping_resp_c6");
        step(2'b01, mk(0, 1, 0, 0, 1, 4'd0), "ping_ok_c7");
        idle(3, 4'd0, "ping_post");

        // back-to-back pings without an idle gap
        step(2'b10, mk(0, 1, 0, 0, 0, 4'd0), "b2b_c0");
        step(2'b01, mk(1, 0, 0, 0, 0, 4'd0), "b2b_c1");
        step(2'b10, mk(0, 1, 0, 0, 1, 4'd0), "b2b_c2");
        step(2'b01, mk(1, 0, 0, 0, 0, 4'd0), "b2b_c3");
        step(2'b01, mk(0, 1, 0, 0, 1, 4'd0), "b2b_c4");
        idle(2, 4'd0, "b2b_post");

        // 3: escalation, esc_p high cycles 5..14
        idle(5, 4'd0, "esc_pre");
        step(2'b10, mk(0, 1, 0, 0, 0, 4'd0), "esc_c5");
        step(2'b10, mk(1, 0, 0, 0, 0, 4'd0), "esc_c6");
        step(2'b10, mk(0, 1, 1, 0, 0, 4'd1), "esc_c7");
        esc_run(1, 7, "esc_body");
        step(2'b01, mk(0, 1, 1, 0, 0, 4'd9), "esc_c15");
        idle(3, 4'd9, "esc_exit_hold9");

        // 4: signal-integrity fault, (1,1) cycles 5..8
        idle(5, 4'd9, "sig_pre");
        step(2'b11, mk(0, 1, 0, 0, 0, 4'd9), "sig_c5");
        step(2'b11, mk(1, 1, SIG_REQ, 1, 0, 4'd9), "sig_c6");
        step(2'b11, mk(0, 0, SIG_REQ, 1, 0, 4'd9), "sig_c7");
        step(2'b11, mk(1, 1, SIG_REQ, 1, 0, 4'd9), "sig_c8");
        step(2'b01, mk(0, 0, SIG_REQ, 1, 0, 4'd9), "sig_c9");
        step(2'b01, mk(0, 1, 0, 0, 0, 4'd9), "sig_c10");
        idle(2, 4'd9, "sig_post");

        // fault followed directly by a clean high level: treated as a new ping
        step(2'b11, mk(0, 1, 0, 0, 0, 4'd9), "sig2chk_c0");
        step(2'b10, mk(1, 1, SIG_REQ, 1, 0, 4'd9), "sig2chk_c1");
        step(2'b01, mk(1, 0, 0, 0, 0, 4'd9), "sig2chk_c2");
        step(2'b01, mk(0, 1, 0, 0, 1, 4'd9), "sig2chk_c3");
        idle(2, 4'd9, "sig2chk_post");

        // 5: saturation, 40 cycles of esc_p high
        step(2'b10, mk(0, 1, 0, 0, 0, 4'd9), "sat_c0");
        step(2'b10, mk(1, 0, 0, 0, 0, 4'd9), "sat_c1");
        step(2'b10, mk(0, 1, 1, 0, 0, 4'd1), "sat_c2");
        esc_run(1, 37, "sat_body");
        step(2'b01, mk(0, 1, 1, 0, 0, 4'd15), "sat_c40");
        idle(4, 4'd15, "sat_hold15");

        // 6: asynchronous reset while in ESC (cycle 10)
        step(2'b10, mk(0, 1, 0, 0, 0, 4'd15), "rst_c0");
        step(2'b10, mk(1, 0, 0, 0, 0, 4'd15), "rst_c1");
        step(2'b10, mk(0, 1, 1, 0, 0, 4'd1), "rst_c2");
        esc_run(1, 7, "rst_esc_body");
        step(2'b01, mk(0, 1, 0, 0, 0, 4'd0), "rst_async_c10");
        #1 rst_n = 1'b0;
        step(2'b01, mk(0, 1, 0, 0, 0, 4'd0), "rst_held");
        #1 rst_n = 1'b1;
        idle(3, 4'd0, "rst_post_idle");
        step(2'b10, mk(0, 1, 0, 0, 0, 4'd0), "rst_ping_c0");
        step(2'b01, mk(1, 0, 0, 0, 0, 4'd0), "rst_ping_resp");
        step(2'b01, mk(0, 1, 0, 0, 1, 4'd0), "rst_ping_ok");
        idle(2, 4'd0, "rst_ping_post");

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
